// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Purpose  : Control/handshake bundle between the multicycle controller and the
//            shared RV32I datapath and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       branch_taken;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemReq;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       IllegalOp;
  logic       InstrDone;

  modport master (
    input  op, mem_ready, branch_taken,
    output PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp, InstrDone
  );

  modport slave (
    output op, mem_ready, branch_taken,
    input  PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp, InstrDone
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Moore control FSM sequencing a shared-ALU, unified-memory RV32I
//            datapath one instruction at a time with a memory ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  wire logic         clk,
  input  wire logic         reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_UNUSED    = 4'd15
  } state_t;

  // Per-state output image; held in flops so outputs are glitch-free Moore
  // decodes, with only the handshake gating applied afterwards.
  typedef struct packed {
    logic       memreq;
    logic       adrsrc;
    logic       memwrite;
    logic       fetch;
    logic       pcw;
    logic       brn;
    logic       regwrite;
    logic       done;
    logic       decode;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctl_t;

  function automatic logic f_known(input logic [6:0] o);
    case (o)
      c_OP_LOAD, c_OP_STORE, c_OP_R, c_OP_I, c_OP_BRANCH,
      c_OP_JAL, c_OP_JALR, c_OP_LUI, c_OP_AUIPC: f_known = 1'b1;
      default:                                    f_known = 1'b0;
    endcase
  endfunction

  function automatic state_t f_next(input state_t s, input logic [6:0] o, input logic rdy);
    case (s)
      S_FETCH:     f_next = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (o)
          c_OP_LOAD, c_OP_STORE: f_next = S_MEMADR;
          c_OP_R:                f_next = S_EXECR;
          c_OP_I:                f_next = S_EXECI;
          c_OP_BRANCH:           f_next = S_BRANCH;
          c_OP_JAL:              f_next = S_JAL;
          c_OP_JALR:             f_next = S_JALR;
          c_OP_LUI:              f_next = S_LUI;
          c_OP_AUIPC:            f_next = S_AUIPC;
          default:               f_next = S_FETCH;
        endcase
      end
      S_MEMADR:    f_next = (o == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   f_next = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:  f_next = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:     f_next = S_ALUWB;
      S_EXECI:     f_next = S_ALUWB;
      S_AUIPC:     f_next = S_ALUWB;
      S_JAL:       f_next = S_ALUWB;
      S_JALR:      f_next = S_JALR_LINK;
      S_JALR_LINK: f_next = S_ALUWB;
      S_MEMWB:     f_next = S_FETCH;
      S_ALUWB:     f_next = S_FETCH;
      S_BRANCH:    f_next = S_FETCH;
      S_LUI:       f_next = S_FETCH;
      S_UNUSED:    f_next = S_FETCH;
    endcase
  endfunction

  function automatic ctl_t f_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memreq = 1'b1; c.fetch = 1'b1;
        c.resultsrc = 2'b10; c.alusrcb = 2'b10;
      end
      S_DECODE: begin
        c.decode = 1'b1; c.alusrca = 2'b01; c.alusrcb = 2'b01;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10; c.alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        c.memreq = 1'b1; c.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01; c.regwrite = 1'b1; c.done = 1'b1;
      end
      S_MEMWRITE: begin
        c.memreq = 1'b1; c.memwrite = 1'b1; c.adrsrc = 1'b1;
      end
      S_EXECR: begin
        c.alusrca = 2'b10; c.aluop = 2'b10;
      end
      S_EXECI: begin
        c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10;
      end
      S_AUIPC: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b01;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1; c.done = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 2'b10; c.aluop = 2'b01; c.brn = 1'b1; c.done = 1'b1;
      end
      S_JAL: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcw = 1'b1;
      end
      S_JALR: begin
        c.alusrca = 2'b10; c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.pcw = 1'b1;
      end
      S_JALR_LINK: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b10;
      end
      S_LUI: begin
        c.resultsrc = 2'b11; c.regwrite = 1'b1; c.done = 1'b1;
      end
      S_UNUSED: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctl_t   r_ctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctl   <= f_decode(S_FETCH);
    end else begin
      r_state <= f_next(r_state, bus.op, bus.mem_ready);
      r_ctl   <= f_decode(f_next(r_state, bus.op, bus.mem_ready));
    end
  end

  logic w_run;
  logic w_illegal;
  logic w_fetch_done;

  // Reset gates every strobe combinationally so they drop the instant reset rises.
  assign w_run        = ~reset;
  assign w_illegal    = r_ctl.decode & ~f_known(bus.op);
  assign w_fetch_done = r_ctl.fetch & bus.mem_ready;

  assign bus.MemReq    = r_ctl.memreq & w_run;
  assign bus.MemWrite  = r_ctl.memwrite & w_run;
  assign bus.IRWrite   = w_fetch_done & w_run;
  assign bus.PCWrite   = (w_fetch_done | r_ctl.pcw | (r_ctl.brn & bus.branch_taken)) & w_run;
  assign bus.RegWrite  = r_ctl.regwrite & w_run;
  assign bus.IllegalOp = w_illegal & w_run;
  assign bus.InstrDone = (r_ctl.done | (r_ctl.memwrite & bus.mem_ready) | w_illegal) & w_run;
  assign bus.AdrSrc    = r_ctl.adrsrc;
  assign bus.ResultSrc = r_ctl.resultsrc;
  assign bus.ALUSrcA   = r_ctl.alusrca;
  assign bus.ALUSrcB   = r_ctl.alusrcb;
  assign bus.ALUOp     = r_ctl.aluop;

  always_comb begin
    case (bus.op)
      c_OP_STORE:          bus.ImmSrc = 3'b001;
      c_OP_BRANCH:         bus.ImmSrc = 3'b010;
      c_OP_LUI, c_OP_AUIPC: bus.ImmSrc = 3'b011;
      c_OP_JAL:            bus.ImmSrc = 3'b100;
      default:             bus.ImmSrc = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench; per-instruction cycle schedules are built
//            from the instruction timing table and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011,
                         ITYP = 7'b0010011, BRAN = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  // Expected-cycle schedule: what to drive and what to see in each cycle.
  bit          q_mr[$];
  bit          q_bt[$];
  logic [6:0]  q_op[$];
  logic [18:0] q_exp[$];
  string       q_tag[$];
  logic [6:0]  cur_op;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return (o == LOAD) || (o == STORE) || (o == RTYP) || (o == ITYP) || (o == BRAN) ||
           (o == JAL) || (o == JALR) || (o == LUI) || (o == AUIPC);
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == STORE) return 3'b001;
    if (o == BRAN) return 3'b010;
    if (o == LUI || o == AUIPC) return 3'b011;
    if (o == JAL) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [18:0] act_vec();
    return {bus.PCWrite, bus.AdrSrc, bus.MemReq, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
            bus.IllegalOp, bus.InstrDone};
  endfunction

  // One cycle: drive values, then strobes {pcw,adr,mreq,mw,irw,rw} and selects.
  task automatic push(input string tag, input bit mr, input bit bt, input logic [5:0] strb,
                      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] aop, input bit ill, input bit done);
    q_tag.push_back(tag);
    q_mr.push_back(mr);
    q_bt.push_back(bt);
    q_op.push_back(cur_op);
    q_exp.push_back({strb, rs, sa, sb, aop, imm_of(cur_op), ill, done});
  endtask

  task automatic gen_instr(input logic [6:0] o, input int fw, input int mw, input bit bt);
    bit ill;
    cur_op = o;
    ill = !legal(o);
    for (int i = 0; i < fw; i++)
      push("fetch_wait", 1'b0, rnd(), 6'b001000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    push("fetch", 1'b1, rnd(), 6'b101010, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    push("decode", rnd(), rnd(), 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, ill, ill);
    if (ill) return;
    case (o)
      LOAD, STORE: begin
        push("memadr", rnd(), rnd(), 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i <= mw; i++) begin
          if (o == LOAD)
            push("memread", (i == mw), rnd(), 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
          else
            push("memwrite", (i == mw), rnd(), 6'b011100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, (i == mw));
        end
        if (o == LOAD)
          push("memwb", rnd(), rnd(), 6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        return;
      end
      RTYP:  push("execr", rnd(), rnd(), 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0);
      ITYP:  push("execi", rnd(), rnd(), 6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0);
      AUIPC: push("auipc", rnd(), rnd(), 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
      JAL:   push("jal", rnd(), rnd(), 6'b100000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
      JALR: begin
        push("jalr", rnd(), rnd(), 6'b100000, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
        push("jalr_link", rnd(), rnd(), 6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
      end
      BRAN: begin
        push("branch", rnd(), bt, {bt, 5'b00000}, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1);
        return;
      end
      LUI: begin
        push("lui", rnd(), rnd(), 6'b000001, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        return;
      end
      default: return;
    endcase
    push("aluwb", rnd(), rnd(), 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  // Entered at posedge+1; returns at posedge+1 of the cycle after the last one played.
  task automatic play(input int n);
    for (int k = 0; k < n && q_exp.size() > 0; k++) begin
      bus.mem_ready    = q_mr.pop_front();
      bus.branch_taken = q_bt.pop_front();
      bus.op           = q_op.pop_front();
      @(negedge clk);
      check_eq(q_tag.pop_front(), 32'(act_vec()), 32'(q_exp.pop_front()));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [18:0] reset_vec(input logic [6:0] o);
    return {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, imm_of(o), 1'b0, 1'b0};
  endfunction

  logic [6:0] ops [9] = '{LOAD, STORE, RTYP, ITYP, BRAN, JAL, JALR, LUI, AUIPC};

  initial begin
    bus.op = RTYP;
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("reset_hold", 32'(act_vec()), 32'(reset_vec(bus.op)));
    end
    @(posedge clk);
    #1 reset = 1'b0;

    gen_instr(RTYP, 0, 0, 1'b0);
    gen_instr(LOAD, 0, 3, 1'b0);
    gen_instr(STORE, 0, 0, 1'b0);
    gen_instr(BRAN, 0, 0, 1'b1);
    gen_instr(BRAN, 0, 0, 1'b0);
    gen_instr(JALR, 0, 0, 1'b0);
    gen_instr(7'b1111111, 0, 0, 1'b0);
    gen_instr(JAL, 1, 0, 1'b0);
    gen_instr(AUIPC, 0, 0, 1'b0);
    gen_instr(LUI, 2, 0, 1'b0);
    gen_instr(ITYP, 0, 0, 1'b0);
    gen_instr(STORE, 1, 2, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      gen_instr(o, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : 0, rnd());
    end
    play(q_exp.size());

    // Abort a store stalled on memory: fetch, decode, memadr, first wait cycle.
    gen_instr(STORE, 0, 5, 1'b0);
    play(4);
    bus.mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check_eq("rst_memreq", 32'(bus.MemReq), 32'd0);
    check_eq("rst_vec", 32'(act_vec()), 32'(reset_vec(bus.op)));
    q_mr.delete(); q_bt.delete(); q_op.delete(); q_exp.delete(); q_tag.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    gen_instr(LUI, 2, 0, 1'b0);
    gen_instr(RTYP, 0, 0, 1'b0);
    play(q_exp.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
